latch_q_monitor: RTL and testbench

// Downstream consumer of the d_latch output q. Brings the asynchronous

---
 rtl/latch_q_monitor.sv | 131 +++++++++++++
 tb/tb_latch_q_monitor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/latch_q_monitor.sv
// Clock-domain monitor for an asynchronous latch output: sync, edge pulses, counters.
// Optional glitch filter enabled by defining LATCH_MON_FILTER_EN.
module latch_q_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             q_in,
    input  logic             clr,
    output logic             q_sync,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] rise_cnt,
    output logic [CNT_W-1:0] fall_cnt,
    output logic             cnt_ovf
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES out of range 2..4");
    end
    if (FILT_CYCLES < 2 || FILT_CYCLES > 15) begin : g_bad_filt
        $error("FILT_CYCLES out of range 2..15");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   s_out;
    logic                   q_prev;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], q_in};
        end
    end

    assign s_out = sync_ff[SYNC_STAGES-1];

`ifdef LATCH_MON_FILTER_EN
    localparam int FC_W = $clog2(FILT_CYCLES + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILT_CYCLES - 1);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_QUAL = 1'b1;

    logic [0:0]      state;
    logic [FC_W-1:0] fcnt;
    logic            q_filt;

    // A new level is accepted only after holding for FILT_CYCLES samples.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= S_IDLE;
            fcnt   <= '0;
            q_filt <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (s_out != q_filt) begin
                        state <= S_QUAL;
                        fcnt  <= FC_W'(1);
                    end
                end
                S_QUAL: begin
                    if (s_out == q_filt) begin
                        state <= S_IDLE;
                        fcnt  <= '0;
                    end else if (fcnt == FC_LAST) begin
                        q_filt <= s_out;
                        state  <= S_IDLE;
                        fcnt   <= '0;
                    end else begin
                        fcnt <= fcnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    fcnt  <= '0;
                end
            endcase
        end
    end

    assign q_sync = q_filt;
`else
    assign q_sync = s_out;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_prev <= 1'b0;
        end else begin
            q_prev <= q_sync;
        end
    end

    assign rise = q_sync & ~q_prev;
    assign fall = ~q_sync & q_prev;

    // Clear takes priority, so an edge coinciding with clr is dropped.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rise_cnt <= '0;
            fall_cnt <= '0;
            cnt_ovf  <= 1'b0;
        end else if (clr) begin
            rise_cnt <= '0;
            fall_cnt <= '0;
            cnt_ovf  <= 1'b0;
        end else begin
            if (rise) begin
                if (rise_cnt == CNT_MAX) begin
                    cnt_ovf <= 1'b1;
                end else begin
                    rise_cnt <= rise_cnt + 1'b1;
                end
            end
            if (fall) begin
                if (fall_cnt == CNT_MAX) begin
                    cnt_ovf <= 1'b1;
                end else begin
                    fall_cnt <= fall_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_latch_q_monitor.sv
// Scoreboard bench for latch_q_monitor against a behavioural model.
// Honours LATCH_MON_FILTER_EN in the same way as the design.
module tb_latch_q_monitor;

    localparam int S    = 2;
    localparam int F    = 4;
    localparam int W    = 8;
    localparam int MAXC = (1 << W) - 1;
`ifdef LATCH_MON_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif
    localparam int HOLD = FILT ? F + 2 : 2;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         q_in = 1'b0;
    logic         clr = 1'b0;
    logic         q_sync;
    logic         rise;
    logic         fall;
    logic [W-1:0] rise_cnt;
    logic [W-1:0] fall_cnt;
    logic         cnt_ovf;

    always #5 clk = ~clk;

    latch_q_monitor #(
        .SYNC_STAGES(S),
        .FILT_CYCLES(F),
        .CNT_W      (W)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .q_in    (q_in),
        .clr     (clr),
        .q_sync  (q_sync),
        .rise    (rise),
        .fall    (fall),
        .rise_cnt(rise_cnt),
        .fall_cnt(fall_cnt),
        .cnt_ovf (cnt_ovf)
    );

    typedef struct {
        bit qs;
        bit r;
        bit f;
        int rc;
        int fc;
        bit ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: q_in delayed S samples; with filter, a level is taken once
    // the delayed value has disagreed with q_sync for F consecutive samples.
    bit hist[$];
    bit qf;
    int run;
    bit m_qs, m_r, m_f, m_ovf;
    int m_rc, m_fc;

    always @(posedge clk) begin : model
        exp_t e;
        bit   s_old;
        bit   prev;
        if (!rstn) begin
            hist = {};
            for (int i = 0; i < S; i++) hist.push_back(1'b0);
            qf = 0; run = 0;
            m_qs = 0; m_r = 0; m_f = 0;
            m_rc = 0; m_fc = 0; m_ovf = 0;
        end else begin
            if (clr) begin
                m_rc = 0; m_fc = 0; m_ovf = 0;
            end else begin
                if (m_r) begin
                    if (m_rc == MAXC) m_ovf = 1; else m_rc++;
                end
                if (m_f) begin
                    if (m_fc == MAXC) m_ovf = 1; else m_fc++;
                end
            end
            s_old = hist[0];
            if (FILT) begin
                run = (s_old != qf) ? run + 1 : 0;
                if (run == F) begin
                    qf  = s_old;
                    run = 0;
                end
            end
            hist.push_back(q_in);
            void'(hist.pop_front());
            prev = m_qs;
            m_qs = FILT ? qf : hist[0];
            m_r  = m_qs & ~prev;
            m_f  = ~m_qs & prev;
        end
        e.qs = m_qs; e.r = m_r; e.f = m_f;
        e.rc = m_rc; e.fc = m_fc; e.ovf = m_ovf;
        exp_q.push_back(e);
    end

    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk("q_sync", int'(q_sync), int'(e.qs));
            chk("rise", int'(rise), int'(e.r));
            chk("fall", int'(fall), int'(e.f));
            chk("rise_cnt", int'(rise_cnt), e.rc);
            chk("fall_cnt", int'(fall_cnt), e.fc);
            chk("cnt_ovf", int'(cnt_ovf), int'(e.ovf));
        end
    end

    task automatic hold(input bit v, input int n);
        q_in = v;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0; q_in = 1'b1; clr = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        hold(1'b1, 12);

        for (int i = 0; i < 3; i++) begin
            hold(1'b0, 10);
            hold(1'b1, 10);
        end
        hold(1'b0, 12);

        // clr landing in the same cycle as a rise pulse
        q_in = 1'b1;
        for (int i = 0; i < 40 && !rise; i++) @(negedge clk);
        if (!rise) chk("rise_wait_timeout", 0, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        hold(1'b1, 8);

        for (int i = 0; i < 300; i++) begin
            hold(1'b0, HOLD);
            hold(1'b1, HOLD);
        end
        hold(1'b1, 4);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;

        for (int i = 0; i < 2; i++) begin
            hold(1'b0, 10);
            hold(1'b1, 10);
        end
        hold(1'b0, 10);
        q_in = 1'b1;
        repeat (S + 2) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("async_rst_q_sync", int'(q_sync), 0);
        chk("async_rst_rise_cnt", int'(rise_cnt), 0);
        chk("async_rst_fall_cnt", int'(fall_cnt), 0);
        chk("async_rst_ovf", int'(cnt_ovf), 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        hold(1'b1, 15);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) q_in = ~q_in;
            clr  = ($urandom_range(0, 29) == 0);
            rstn = ($urandom_range(0, 299) != 0);
        end
        rstn = 1'b1;
        clr  = 1'b0;
        hold(q_in, 20);

        chk("scoreboard_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
